ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/gpu_pkg.sv | 17 +
 rtl/arb_starve_sel.sv | 50 +++++
 rtl/ram_port_arbiter.sv | 131 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: arbiter state encoding, port owner codes and default
// layer RAM address width.
package gpu_pkg;

  localparam int DEFAULT_ADDR_W = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arbState_e;

  localparam logic OWNER_HOST = 1'b0;
  localparam logic OWNER_REND = 1'b1;

endpackage

// File: rtl/arb_starve_sel.sv
// Host/render winner select with a starvation counter that lets the host
// through after STARVE_MAX consecutive render grants while it waits.
module arb_starve_sel
  import gpu_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic gpuClock,
  input  logic reset,
  input  logic arbEn,
  input  logic hostReq,
  input  logic rendReq,
  input  logic rendering,
  output logic grantValid,
  output logic grantOwner
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starveCnt;
  logic             hostStarved;

  assign hostStarved = (starveCnt == CNT_W'(STARVE_MAX));

  always_comb begin
    grantValid = hostReq | rendReq;
    grantOwner = OWNER_HOST;
    if (rendering) begin
      // render has priority during a frame, but a starved host gets one slot
      if (rendReq && !(hostReq && hostStarved)) begin
        grantOwner = OWNER_REND;
      end
    end else if (!hostReq) begin
      grantOwner = OWNER_REND;
    end
  end

  always_ff @(posedge gpuClock or posedge reset) begin
    if (reset) begin
      starveCnt <= '0;
    end else if (arbEn && grantValid) begin
      if (grantOwner == OWNER_HOST) begin
        starveCnt <= '0;
      end else if (hostReq && !hostStarved) begin
        starveCnt <= starveCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port layer RAM arbiter between host command accesses and render
// pipeline reads: arbitrate, issue one RAM op, wait (with timeout), respond.
module ram_port_arbiter
  import gpu_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int STARVE_MAX = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic              gpuClock,
  input  logic              reset,
  input  logic              hostReq,
  input  logic              hostWrite,
  input  logic [ADDR_W-1:0] hostAddr,
  input  logic [15:0]       hostWData,
  output logic              hostAck,
  output logic [15:0]       hostRData,
  output logic              hostErr,
  input  logic              rendReq,
  input  logic [ADDR_W-1:0] rendAddr,
  output logic              rendAck,
  output logic [15:0]       rendRData,
  output logic              rendErr,
  input  logic              rendering,
  output logic              memStart,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddr,
  output logic [15:0]       memWData,
  input  logic              memDone,
  input  logic [15:0]       memRData,
  output logic              busy,
  output logic              owner
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  arbState_e        stateReg, stateNext;
  logic [TMO_W-1:0] waitCnt;
  logic             ownerReg;
  logic             grantValid, grantOwner;
  logic             arbEn, timedOut;

  assign arbEn    = (stateReg == IDLE);
  assign timedOut = (waitCnt == TMO_W'(TIMEOUT - 1));

  arb_starve_sel #(
    .STARVE_MAX(STARVE_MAX)
  ) u_sel (
    .gpuClock  (gpuClock),
    .reset     (reset),
    .arbEn     (arbEn),
    .hostReq   (hostReq),
    .rendReq   (rendReq),
    .rendering (rendering),
    .grantValid(grantValid),
    .grantOwner(grantOwner)
  );

  always_ff @(posedge gpuClock or posedge reset) begin
    if (reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (grantValid) stateNext = ISSUE;
      ISSUE:   stateNext = WAIT;
      WAIT:    if (memDone || timedOut) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge gpuClock or posedge reset) begin
    if (reset) begin
      ownerReg  <= OWNER_HOST;
      memWrite  <= 1'b0;
      memAddr   <= '0;
      memWData  <= '0;
      waitCnt   <= '0;
      hostRData <= '0;
      hostErr   <= 1'b0;
      rendRData <= '0;
      rendErr   <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (grantValid) begin
            ownerReg <= grantOwner;
            if (grantOwner == OWNER_HOST) begin
              memWrite <= hostWrite;
              memAddr  <= hostAddr;
              memWData <= hostWData;
            end else begin
              memWrite <= 1'b0;
              memAddr  <= rendAddr;
              memWData <= '0;
            end
          end
        end
        ISSUE: waitCnt <= '0;
        WAIT: begin
          // response registers load on the way into RESP so they are valid with Ack
          if (memDone || timedOut) begin
            if (ownerReg == OWNER_HOST) begin
              hostRData <= memDone ? memRData : 16'h0;
              hostErr   <= !memDone;
            end else begin
              rendRData <= memDone ? memRData : 16'h0;
              rendErr   <= !memDone;
            end
          end else begin
            waitCnt <= waitCnt + TMO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign memStart = (stateReg == ISSUE);
  assign hostAck  = (stateReg == RESP) && (ownerReg == OWNER_HOST);
  assign rendAck  = (stateReg == RESP) && (ownerReg == OWNER_REND);
  assign busy     = (stateReg != IDLE);
  assign owner    = ownerReg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a behavioural RAM answers memStart
// after a programmable delay; expected grants/responses are queued per request.
module tb_ram_port_arbiter;

  localparam int ADDR_W     = 20;
  localparam int STARVE_MAX = 8;
  localparam int TIMEOUT    = 255;

  logic              gpuClock = 1'b0;
  logic              reset;
  logic              hostReq, hostWrite, hostAck, hostErr;
  logic [ADDR_W-1:0] hostAddr;
  logic [15:0]       hostWData, hostRData;
  logic              rendReq, rendAck, rendErr, rendering;
  logic [ADDR_W-1:0] rendAddr;
  logic [15:0]       rendRData;
  logic              memStart, memWrite, memDone, busy, owner;
  logic [ADDR_W-1:0] memAddr;
  logic [15:0]       memWData, memRData;

  ram_port_arbiter #(
    .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .gpuClock(gpuClock), .reset(reset),
    .hostReq(hostReq), .hostWrite(hostWrite), .hostAddr(hostAddr), .hostWData(hostWData),
    .hostAck(hostAck), .hostRData(hostRData), .hostErr(hostErr),
    .rendReq(rendReq), .rendAddr(rendAddr),
    .rendAck(rendAck), .rendRData(rendRData), .rendErr(rendErr),
    .rendering(rendering),
    .memStart(memStart), .memWrite(memWrite), .memAddr(memAddr), .memWData(memWData),
    .memDone(memDone), .memRData(memRData),
    .busy(busy), .owner(owner)
  );

  always #5 gpuClock = ~gpuClock;

  typedef struct {
    logic              owner;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic [15:0]       rdata;
    logic              err;
  } exp_t;

  exp_t sbq[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   cyc = 0;

  always @(posedge gpuClock) cyc++;

  // behavioural RAM: memDone arrives memDelay cycles after memStart unless memHang
  int          pendCnt = 0;
  int          memDelay = 2;
  bit          memHang = 1'b0;
  logic [15:0] memRDataVal = 16'h0;

  always @(negedge gpuClock) begin
    memDone  = 1'b0;
    memRData = 16'h0;
    if (reset) begin
      pendCnt = 0;
    end else begin
      if (pendCnt > 0) begin
        pendCnt--;
        if (pendCnt == 0) begin
          memDone  = 1'b1;
          memRData = memRDataVal;
        end
      end
      if (memStart && !memHang) pendCnt = memDelay;
    end
  end

  task automatic waitStart(input int maxCyc, output int c, output bit ok);
    ok = 1'b0; c = 0;
    for (int i = 0; i < maxCyc && !ok; i++) begin
      @(negedge gpuClock);
      if (memStart) begin ok = 1'b1; c = cyc; end
    end
  endtask

  task automatic waitAck(input int maxCyc, output int c, output bit ok);
    ok = 1'b0; c = 0;
    for (int i = 0; i < maxCyc && !ok; i++) begin
      @(negedge gpuClock);
      if (hostAck || rendAck) begin ok = 1'b1; c = cyc; end
    end
  endtask

  task automatic test_reset();
    logic [75:0] outs;
    reset = 1'b1;
    repeat (3) @(negedge gpuClock);
    outs = {memStart, memWrite, memAddr, memWData, hostAck, rendAck, hostErr, rendErr,
            hostRData, rendRData, busy, owner};
    testsRun++;
    if (outs !== '0) begin
      testsFailed++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    reset = 1'b0;
    repeat (2) @(negedge gpuClock);
    testsRun++;
    if (busy !== 1'b0 || memStart !== 1'b0) begin
      testsFailed++; $display("FAIL reset_idle: busy=%b memStart=%b expected 0/0", busy, memStart);
    end
  endtask

  task automatic test_host_write();
    int reqCyc, c; bit ok; exp_t e;
    rendering = 1'b0; hostWrite = 1'b1; hostAddr = 20'h00010; hostWData = 16'hBEEF;
    memDelay = 2; memHang = 1'b0; memRDataVal = 16'h7777; hostReq = 1'b1;
    reqCyc = cyc;
    e.owner = 1'b0; e.write = 1'b1; e.addr = 20'h00010; e.wdata = 16'hBEEF;
    e.rdata = 16'h7777; e.err = 1'b0;
    sbq.push_back(e);
    waitStart(20, c, ok);
    testsRun++;
    if (!ok || c != reqCyc + 1) begin
      testsFailed++; $display("FAIL hw_start_latency: got cycle %0d (seen=%b) expected %0d", c, ok, reqCyc + 1);
    end
    testsRun++;
    if (memWrite !== sbq[0].write || memAddr !== sbq[0].addr || memWData !== sbq[0].wdata || owner !== sbq[0].owner) begin
      testsFailed++;
      $display("FAIL hw_mem_fields: got w=%b a=%h d=%h o=%b expected w=%b a=%h d=%h o=%b",
               memWrite, memAddr, memWData, owner, sbq[0].write, sbq[0].addr, sbq[0].wdata, sbq[0].owner);
    end
    waitAck(20, c, ok);
    e = sbq.pop_front();
    testsRun++;
    if (!ok || c != reqCyc + 4 || hostAck !== 1'b1 || rendAck !== 1'b0) begin
      testsFailed++; $display("FAIL hw_ack: got cycle %0d host=%b rend=%b expected cycle %0d host=1 rend=0", c, hostAck, rendAck, reqCyc + 4);
    end
    testsRun++;
    if (hostErr !== e.err || hostRData !== e.rdata) begin
      testsFailed++; $display("FAIL hw_resp: got err=%b rdata=%h expected err=%b rdata=%h", hostErr, hostRData, e.err, e.rdata);
    end
    hostReq = 1'b0;
    @(negedge gpuClock);
    testsRun++;
    if (hostAck !== 1'b0 || busy !== 1'b0) begin
      testsFailed++; $display("FAIL hw_ack_pulse: got ack=%b busy=%b expected 0/0", hostAck, busy);
    end
  endtask

  task automatic test_render_read();
    int c; bit ok; exp_t e;
    rendering = 1'b1; rendAddr = 20'h00020; memRDataVal = 16'h1234; memDelay = 1; rendReq = 1'b1;
    e.owner = 1'b1; e.write = 1'b0; e.addr = 20'h00020; e.wdata = 16'h0; e.rdata = 16'h1234; e.err = 1'b0;
    sbq.push_back(e);
    waitStart(20, c, ok);
    testsRun++;
    if (!ok || owner !== sbq[0].owner || memWrite !== sbq[0].write || memAddr !== sbq[0].addr || memWData !== sbq[0].wdata) begin
      testsFailed++;
      $display("FAIL rr_mem_fields: got seen=%b o=%b w=%b a=%h d=%h expected o=1 w=0 a=%h d=0",
               ok, owner, memWrite, memAddr, memWData, sbq[0].addr);
    end
    waitAck(20, c, ok);
    e = sbq.pop_front();
    testsRun++;
    if (!ok || rendAck !== 1'b1 || hostAck !== 1'b0 || owner !== e.owner) begin
      testsFailed++; $display("FAIL rr_ack: got seen=%b rend=%b host=%b owner=%b expected 1/0/1", ok, rendAck, hostAck, owner);
    end
    testsRun++;
    if (rendRData !== e.rdata || rendErr !== e.err) begin
      testsFailed++; $display("FAIL rr_resp: got rdata=%h err=%b expected %h/%b", rendRData, rendErr, e.rdata, e.err);
    end
    testsRun++;
    if (hostRData !== 16'h7777) begin
      testsFailed++; $display("FAIL rr_host_hold: got hostRData=%h expected 7777", hostRData);
    end
    rendReq = 1'b0;
    @(negedge gpuClock);
  endtask

  task automatic test_starvation();
    int c, cnt; bit ok; exp_t e;
    cnt = 0;
    rendering = 1'b1; memDelay = 1;
    hostWrite = 1'b1; hostAddr = 20'h00100; hostWData = 16'h55AA; hostReq = 1'b1;
    rendAddr = 20'h00200; rendReq = 1'b1;
    for (int i = 0; i < 2 * (STARVE_MAX + 1); i++) begin
      memRDataVal = 16'h1000 + 16'(i);
      if (cnt == STARVE_MAX) begin
        e.owner = 1'b0; e.write = 1'b1; e.addr = 20'h00100; e.wdata = 16'h55AA; cnt = 0;
      end else begin
        e.owner = 1'b1; e.write = 1'b0; e.addr = 20'h00200; e.wdata = 16'h0; cnt++;
      end
      e.rdata = memRDataVal; e.err = 1'b0;
      sbq.push_back(e);
      waitStart(20, c, ok);
      testsRun++;
      if (!ok || owner !== sbq[0].owner || memAddr !== sbq[0].addr || memWrite !== sbq[0].write || memWData !== sbq[0].wdata) begin
        testsFailed++;
        $display("FAIL starve_grant%0d: got seen=%b o=%b a=%h w=%b d=%h expected o=%b a=%h w=%b d=%h", i,
                 ok, owner, memAddr, memWrite, memWData, sbq[0].owner, sbq[0].addr, sbq[0].write, sbq[0].wdata);
      end
      waitAck(20, c, ok);
      e = sbq.pop_front();
      testsRun++;
      if (!ok || hostAck !== !e.owner || rendAck !== e.owner ||
          (e.owner ? rendRData : hostRData) !== e.rdata) begin
        testsFailed++;
        $display("FAIL starve_ack%0d: got host=%b rend=%b hrd=%h rrd=%h expected owner=%b rdata=%h", i,
                 hostAck, rendAck, hostRData, rendRData, e.owner, e.rdata);
      end
    end
    hostReq = 1'b0; rendReq = 1'b0;
    @(negedge gpuClock);
  endtask

  task automatic test_host_priority();
    int c; bit ok;
    rendering = 1'b0; memDelay = 3; memRDataVal = 16'hA0A0;
    hostWrite = 1'b0; hostAddr = 20'h00044; hostReq = 1'b1;
    rendAddr = 20'h00055; rendReq = 1'b1;
    waitStart(20, c, ok);
    testsRun++;
    if (!ok || owner !== 1'b0 || memAddr !== 20'h00044) begin
      testsFailed++; $display("FAIL prio_host_first: got seen=%b owner=%b addr=%h expected 0/00044", ok, owner, memAddr);
    end
    waitAck(20, c, ok);
    hostReq = 1'b0;
    memRDataVal = 16'hB0B0;
    waitStart(20, c, ok);
    testsRun++;
    if (!ok || owner !== 1'b1 || memAddr !== 20'h00055) begin
      testsFailed++; $display("FAIL prio_rend_next: got seen=%b owner=%b addr=%h expected 1/00055", ok, owner, memAddr);
    end
    waitAck(20, c, ok);
    testsRun++;
    if (!ok || rendAck !== 1'b1 || rendRData !== 16'hB0B0 || hostRData !== 16'hA0A0) begin
      testsFailed++; $display("FAIL prio_resp: got rendAck=%b rrd=%h hrd=%h expected 1/b0b0/a0a0", rendAck, rendRData, hostRData);
    end
    rendReq = 1'b0;
    @(negedge gpuClock);
  endtask

  task automatic test_timeout();
    int s, c; bit ok;
    rendering = 1'b0; memHang = 1'b1; hostWrite = 1'b0; hostAddr = 20'h00033; hostReq = 1'b1;
    waitStart(20, s, ok);
    waitAck(TIMEOUT + 20, c, ok);
    testsRun++;
    if (!ok || c != s + TIMEOUT + 1) begin
      testsFailed++; $display("FAIL tmo_latency: got cycle %0d (seen=%b) expected %0d", c, ok, s + TIMEOUT + 1);
    end
    testsRun++;
    if (hostAck !== 1'b1 || hostErr !== 1'b1 || hostRData !== 16'h0) begin
      testsFailed++; $display("FAIL tmo_resp: got ack=%b err=%b rdata=%h expected 1/1/0000", hostAck, hostErr, hostRData);
    end
    hostReq = 1'b0; memHang = 1'b0;
    @(negedge gpuClock);
    testsRun++;
    if (busy !== 1'b0 || hostErr !== 1'b1) begin
      testsFailed++; $display("FAIL tmo_idle: got busy=%b err=%b expected 0/1", busy, hostErr);
    end
  endtask

  task automatic test_reset_in_wait();
    int s, c, relCyc; bit ok, sawAck; logic [75:0] outs; exp_t e;
    rendering = 1'b0; memHang = 1'b1; hostWrite = 1'b0; hostAddr = 20'h00066; hostReq = 1'b1;
    waitStart(20, s, ok);
    repeat (3) @(negedge gpuClock);
    reset = 1'b1; hostReq = 1'b0; memHang = 1'b0;
    #1;
    outs = {memStart, memWrite, memAddr, memWData, hostAck, rendAck, hostErr, rendErr,
            hostRData, rendRData, busy, owner};
    testsRun++;
    if (outs !== '0) begin
      testsFailed++; $display("FAIL rst_wait_outputs: got %h expected 0", outs);
    end
    sawAck = 1'b0;
    repeat (2) begin
      @(negedge gpuClock);
      sawAck |= hostAck | rendAck;
    end
    rendering = 1'b1; rendAddr = 20'h00077; memRDataVal = 16'hCAFE; memDelay = 2; rendReq = 1'b1;
    reset = 1'b0; relCyc = cyc;
    e.owner = 1'b1; e.write = 1'b0; e.addr = 20'h00077; e.wdata = 16'h0; e.rdata = 16'hCAFE; e.err = 1'b0;
    sbq.push_back(e);
    waitStart(20, c, ok);
    testsRun++;
    if (!ok || c != relCyc + 1 || memAddr !== sbq[0].addr || owner !== sbq[0].owner) begin
      testsFailed++; $display("FAIL rst_wait_restart: got cycle %0d addr=%h owner=%b expected %0d/%h/%b",
                              c, memAddr, owner, relCyc + 1, sbq[0].addr, sbq[0].owner);
    end
    waitAck(20, c, ok);
    e = sbq.pop_front();
    testsRun++;
    if (sawAck || !ok || c != relCyc + 4 || rendAck !== 1'b1 || rendRData !== e.rdata || rendErr !== e.err) begin
      testsFailed++; $display("FAIL rst_wait_resp: got stray=%b cycle %0d ack=%b rdata=%h err=%b expected 0/%0d/1/%h/%b",
                              sawAck, c, rendAck, rendRData, rendErr, relCyc + 4, e.rdata, e.err);
    end
    rendReq = 1'b0;
    @(negedge gpuClock);
  endtask

  initial begin
    reset = 1'b1; hostReq = 1'b0; hostWrite = 1'b0; hostAddr = '0; hostWData = '0;
    rendReq = 1'b0; rendAddr = '0; rendering = 1'b0;
    memDone = 1'b0; memRData = '0;
    @(negedge gpuClock);
    test_reset();
    test_host_write();
    test_render_read();
    test_starvation();
    test_host_priority();
    test_timeout();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
